// File: rtl/serial_deframer.sv
// Serial frame receiver: start, N data bits LSB-first, parity, stop -> parallel word with one-cycle status strobes.
// Latency N+3 enabled edges from start to strobe; en=0 freezes the FSM and datapath (strobes still self-clear).
module serial_deframer #(
  parameter int N          = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Din,
  input  logic         en,
  output logic [N-1:0] Dout,
  output logic         valid,
  output logic         perr,
  output logic         ferr,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BRK
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [N-1:0]  r_data;
  logic [N-1:0]  r_dout;
  logic          r_par;
  logic          r_valid;
  logic          r_perr;
  logic          r_ferr;
  logic          r_busy;
  logic          w_shift;
  logic          w_cap_par;
  logic          w_good;
  logic          w_bad;
  logic          w_par_fail;

  // Data bits plus parity bit must XOR to PARITY_ODD.
  assign w_par_fail = ((^r_data) ^ r_par) != PARITY_ODD;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift      = 1'b0;
    w_cap_par    = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (!Din) begin
            w_state_next = S_DATA;
            w_cnt_next   = '0;
          end
        end
        S_DATA: begin
          w_shift = 1'b1;
          if (r_cnt == LAST) begin
            w_state_next = S_PAR;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
        S_PAR: begin
          w_cap_par    = 1'b1;
          w_state_next = S_STOP;
        end
        S_STOP: begin
          if (Din) begin
            w_good       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_bad        = 1'b1;
            w_state_next = S_BRK;
          end
        end
        S_BRK: begin
          // Line held low after a bad stop: wait for it to return high before hunting for a start bit.
          if (Din) begin
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_shift) begin
        r_data[r_cnt] <= Din;
      end
      if (w_cap_par) begin
        r_par <= Din;
      end
      if (w_good) begin
        r_dout <= r_data;
      end
      r_valid <= w_good;
      r_perr  <= w_good & w_par_fail;
      r_ferr  <= w_bad;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  assign Dout  = r_dout;
  assign valid = r_valid;
  assign perr  = r_perr;
  assign ferr  = r_ferr;
  assign busy  = r_busy;

endmodule

// File: tb/tb_serial_deframer.sv
// Directed bench for serial_deframer (N=4, even parity): vector table plus en-gating and mid-frame reset sequences.
module tb_serial_deframer;

  logic       clk = 1'b0;
  logic       rst;
  logic       Din;
  logic       en;
  logic [3:0] Dout;
  logic       valid;
  logic       perr;
  logic       ferr;
  logic       busy;

  always #5 clk = ~clk;

  serial_deframer #(
    .N         (4),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .Din  (Din),
    .en   (en),
    .Dout (Dout),
    .valid(valid),
    .perr (perr),
    .ferr (ferr),
    .busy (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic       din;
    logic       en;
    logic [3:0] dout;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  int         pulses;
  int         p_t[2];
  logic [3:0] p_d[2];
  logic       p_p[2];

  task automatic add(input logic r, input logic d, input logic e, input logic [3:0] dt,
                     input logic v, input logic p, input logic f, input logic b);
    vec_t x;
    x.rst = r; x.din = d; x.en = e; x.dout = dt;
    x.valid = v; x.perr = p; x.ferr = f; x.busy = b;
    vecs.push_back(x);
  endtask

  // Apply inputs mid-low-phase, clock once, sample 1ns after the edge.
  task automatic step(input logic r, input logic d, input logic e);
    @(negedge clk);
    rst = r;
    Din = d;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic note_pulse(input int c);
    if (valid) begin
      if (pulses < 2) begin
        p_t[pulses] = c;
        p_d[pulses] = Dout;
        p_p[pulses] = perr;
      end
      pulses++;
    end
  endtask

  initial begin
    logic [0:13] fr;
    logic [0:6]  f3;
    int          cyc;
    int          cnt;

    rst = 1'b1;
    Din = 1'b1;
    en  = 1'b0;

    // rst din en | dout valid perr ferr busy
    add(1, 0, 1, 4'h0, 0, 0, 0, 0);
    add(1, 1, 1, 4'h0, 0, 0, 0, 0);
    add(0, 1, 1, 4'h0, 0, 0, 0, 0);
    add(0, 1, 1, 4'h0, 0, 0, 0, 0);
    add(0, 0, 0, 4'h0, 0, 0, 0, 0);   // low line ignored while en=0
    // good frame 4'hD, parity 1
    add(0, 0, 1, 4'h0, 0, 0, 0, 1);
    add(0, 1, 1, 4'h0, 0, 0, 0, 1);
    add(0, 0, 1, 4'h0, 0, 0, 0, 1);
    add(0, 1, 1, 4'h0, 0, 0, 0, 1);
    add(0, 1, 1, 4'h0, 0, 0, 0, 1);
    add(0, 1, 1, 4'h0, 0, 0, 0, 1);
    add(0, 1, 1, 4'hD, 1, 0, 0, 0);
    add(0, 1, 1, 4'hD, 0, 0, 0, 0);
    // 4'hD with wrong parity bit 0
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 1, 1, 4'hD, 0, 0, 0, 1);
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 1, 1, 4'hD, 0, 0, 0, 1);
    add(0, 1, 1, 4'hD, 0, 0, 0, 1);
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 1, 1, 4'hD, 1, 1, 0, 0);
    add(0, 1, 1, 4'hD, 0, 0, 0, 0);
    // 4'hA with stop bit 0, then break held low
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 1, 1, 4'hD, 0, 0, 0, 1);
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 1, 1, 4'hD, 0, 0, 0, 1);
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 0, 1, 4'hD, 0, 0, 1, 1);
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 0, 1, 4'hD, 0, 0, 0, 1);
    add(0, 1, 1, 4'hD, 0, 0, 0, 0);
    add(0, 1, 1, 4'hD, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].din, vecs[i].en);
      check($sformatf("vec%0d {dout,valid,perr,ferr,busy}", i),
            {24'd0, Dout, valid, perr, ferr, busy},
            {24'd0, vecs[i].dout, vecs[i].valid, vecs[i].perr, vecs[i].ferr, vecs[i].busy});
    end

    // 4'hA (parity 0) then 4'h3 (parity 0) back-to-back, en alternating; Din inverted on disabled cycles.
    fr     = 14'b0010101_0110001;
    cyc    = 0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, fr[i], 1'b1);
      note_pulse(cyc);
      cyc++;
      step(1'b0, ~fr[i], 1'b0);
      note_pulse(cyc);
      cyc++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1);
      note_pulse(cyc);
      cyc++;
    end
    check("b2b pulse count", pulses, 2);
    // Start of A at edge 0, start of 3 at edge 14; stop sampled 12 clocks after each start.
    check("b2b A edge", p_t[0], 12);
    check("b2b A data", {28'd0, p_d[0]}, 32'hA);
    check("b2b A perr", {31'd0, p_p[0]}, 0);
    check("b2b 3 edge", p_t[1], 26);
    check("b2b 3 data", {28'd0, p_d[1]}, 32'h3);
    check("b2b 3 perr", {31'd0, p_p[1]}, 0);

    // Reset after two data bits abandons the frame.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("mid-frame busy", {31'd0, busy}, 1);
    step(1'b1, 1'b1, 1'b1);
    check("rst mid {dout,valid,ferr,busy}", {25'd0, Dout, valid, ferr, busy}, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (valid || ferr || busy) cnt++;
    end
    check("post-rst idle events", cnt, 0);

    // 4'h3 has two ones, so even parity needs a 0 parity bit.
    f3  = 7'b0110001;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, f3[i], 1'b1);
      if (valid || perr || ferr) cnt++;
    end
    check("frame3 early strobes", cnt, 0);
    step(1'b0, f3[6], 1'b1);
    check("frame3 {dout,valid,perr,busy}", {25'd0, Dout, valid, perr, busy}, {25'd0, 4'h3, 3'b100});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
